// File: rtl/imem_arb_pkg.sv
// Shared types and default sizes for the instruction-memory arbiter.
package imem_arb_pkg;

   parameter int unsigned DefAddrW      = 14;
   parameter int unsigned DefDataW      = 32;
   parameter int unsigned DefReleaseCyc = 4;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StDrain   = 2'd1,
      StLoad    = 2'd2,
      StRelease = 2'd3
   } arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the arbiter (slave view) and fetch, loader and memory (master view).
// ld_checksum exists only when IMEM_ARB_CHECKSUM_EN is defined.
interface imem_arbiter_if #(
   parameter int unsigned ADDR_W = imem_arb_pkg::DefAddrW,
   parameter int unsigned DATA_W = imem_arb_pkg::DefDataW
);
   logic              load_mode;
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_valid;
   logic              fetch_misalign;
   logic              cpu_stall;
   logic              cpu_rst_req;
   logic [ADDR_W:0]   word_count;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef IMEM_ARB_CHECKSUM_EN
   logic [DATA_W-1:0] ld_checksum;
`endif

   modport slave (
      input  load_mode, ld_valid, ld_addr, ld_data, fetch_req, fetch_addr, mem_rdata,
      output ld_ready, fetch_rdata, fetch_valid, fetch_misalign, cpu_stall, cpu_rst_req,
             word_count, mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_CHECKSUM_EN
      , output ld_checksum
`endif
   );

   modport master (
      output load_mode, ld_valid, ld_addr, ld_data, fetch_req, fetch_addr, mem_rdata,
      input  ld_ready, fetch_rdata, fetch_valid, fetch_misalign, cpu_stall, cpu_rst_req,
             word_count, mem_en, mem_we, mem_addr, mem_wdata
`ifdef IMEM_ARB_CHECKSUM_EN
      , input ld_checksum
`endif
   );

endinterface

// File: rtl/imem_arb_release_timer.sv
// Down-counter timing the CPU reset hold after a load; done_o when it reaches zero.
module imem_arb_release_timer #(
   parameter int unsigned RELEASE_CYC = imem_arb_pkg::DefReleaseCyc
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic done_o
);
   localparam int unsigned CntW = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
   localparam logic [CntW-1:0] LoadVal = CntW'(RELEASE_CYC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LoadVal;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction memory between CPU fetch (RUN) and the UART loader (LOAD).
// Optional running XOR of loaded words on ld_checksum under IMEM_ARB_CHECKSUM_EN.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DefAddrW,
   parameter int unsigned DATA_W      = DefDataW,
   parameter int unsigned RELEASE_CYC = DefReleaseCyc
) (
   input  logic           clk_i,
   input  logic           rst_i,
   imem_arbiter_if.slave  bus
);
   localparam logic [ADDR_W:0] WcMax = {1'b1, {ADDR_W{1'b0}}};

   arb_state_e      state_q, state_d;
   logic [ADDR_W:0] wc_q, wc_d;
   logic            fv_q, fv_d;
   logic            fm_q, fm_d;
   logic            rel_load, rel_done;

   imem_arb_release_timer #(
      .RELEASE_CYC (RELEASE_CYC)
   ) u_release_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (rel_load),
      .done_o (rel_done)
   );

   assign rel_load = (state_q == StLoad) && !bus.load_mode;

   always_comb begin
      state_d         = state_q;
      wc_d            = wc_q;
      fv_d            = 1'b0;
      fm_d            = 1'b0;
      bus.mem_en      = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.ld_ready    = 1'b0;
      bus.cpu_rst_req = 1'b0;
      unique case (state_q)
         StRun: begin
            if (bus.fetch_req) begin
               bus.mem_en   = 1'b1;
               bus.mem_addr = bus.fetch_addr[ADDR_W+1:2];
               fv_d         = 1'b1;
               fm_d         = |bus.fetch_addr[1:0];
            end
            if (bus.load_mode) state_d = StDrain;
         end
         StDrain: begin
            wc_d    = '0;
            state_d = StLoad;
         end
         StLoad: begin
            bus.ld_ready = 1'b1;
            if (bus.ld_valid) begin
               bus.mem_en    = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = bus.ld_addr;
               bus.mem_wdata = bus.ld_data;
               if (wc_q != WcMax) wc_d = wc_q + 1'b1;
            end
            if (!bus.load_mode) state_d = StRelease;
         end
         StRelease: begin
            bus.cpu_rst_req = 1'b1;
            if (bus.load_mode) begin
               state_d = StLoad;
            end else if (rel_done) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
      // Reset cancels any access presented in the same cycle.
      if (rst_i) begin
         bus.mem_en   = 1'b0;
         bus.mem_we   = 1'b0;
         bus.ld_ready = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StRun;
         wc_q    <= '0;
         fv_q    <= 1'b0;
         fm_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         fv_q    <= fv_d;
         fm_q    <= fm_d;
      end
   end

   assign bus.cpu_stall      = (state_q != StRun);
   assign bus.fetch_rdata    = bus.mem_rdata;
   assign bus.fetch_valid    = fv_q;
   assign bus.fetch_misalign = fm_q;
   assign bus.word_count     = wc_q;

`ifdef IMEM_ARB_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == StDrain) begin
         csum_d = '0;
      end else if ((state_q == StLoad) && bus.ld_valid) begin
         csum_d = csum_q ^ bus.ld_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign bus.ld_checksum = csum_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioural memory macro.
module tb_imem_arbiter;
   localparam int unsigned AW = 14;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   imem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   imem_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .RELEASE_CYC (4)
   ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // Memory macro model: unwritten words read back a known pattern.
   logic [31:0] mem_q [64];
   logic [63:0] wr_q = '0;
   logic [31:0] rd_q = '0;
   int          we_cnt = 0;

   function automatic logic [31:0] init_word(input int a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   function automatic logic [31:0] mem_word(input int a);
      return wr_q[a] ? mem_q[a] : init_word(a);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem_q[bus.mem_addr[5:0]] <= bus.mem_wdata;
            wr_q[bus.mem_addr[5:0]]  <= 1'b1;
            we_cnt                   <= we_cnt + 1;
         end else begin
            rd_q <= mem_word(int'(bus.mem_addr[5:0]));
         end
      end
   end

   assign bus.mem_rdata = rd_q;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      #1;
      check("wr_we", 64'(bus.mem_we), 64'd1);
      check("wr_addr", 64'(bus.mem_addr), 64'(a));
      check("wr_data", 64'(bus.mem_wdata), 64'(d));
   endtask

   task automatic idle();
      @(negedge clk);
      bus.ld_valid = 1'b0;
      #1;
   endtask

   logic [31:0] words [3];
   int          n;
   int          we_base;
   bit          stop;

   initial begin
      words[0] = 32'h0000_0013;
      words[1] = 32'h0010_0093;
      words[2] = 32'h0000_006F;
      rst = 1'b1;
      bus.load_mode  = 1'b0;
      bus.ld_valid   = 1'b0;
      bus.ld_addr    = '0;
      bus.ld_data    = '0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_stall", 64'(bus.cpu_stall), 64'd0);
      check("rst_rstreq", 64'(bus.cpu_rst_req), 64'd0);
      check("rst_ready", 64'(bus.ld_ready), 64'd0);
      check("rst_fvalid", 64'(bus.fetch_valid), 64'd0);
      check("rst_wc", 64'(bus.word_count), 64'd0);
      check("rst_memen", 64'(bus.mem_en), 64'd0);

      // Aligned fetch in RUN
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0008;
      #1;
      check("run_memen", 64'(bus.mem_en), 64'd1);
      check("run_memwe", 64'(bus.mem_we), 64'd0);
      check("run_addr", 64'(bus.mem_addr), 64'd2);
      check("run_stall", 64'(bus.cpu_stall), 64'd0);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      check("run_fvalid", 64'(bus.fetch_valid), 64'd1);
      check("run_rdata", 64'(bus.fetch_rdata), 64'hA500_0002);
      check("run_misal", 64'(bus.fetch_misalign), 64'd0);

      // Fetch together with load_mode rising
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0010;
      bus.load_mode  = 1'b1;
      #1;
      check("sw_memen", 64'(bus.mem_en), 64'd1);
      check("sw_addr", 64'(bus.mem_addr), 64'd4);
      @(negedge clk);
      #1;
      check("drain_stall", 64'(bus.cpu_stall), 64'd1);
      check("drain_fvalid", 64'(bus.fetch_valid), 64'd1);
      check("drain_rdata", 64'(bus.fetch_rdata), 64'hA500_0004);
      check("drain_memen", 64'(bus.mem_en), 64'd0);
      check("drain_ready", 64'(bus.ld_ready), 64'd0);
      @(negedge clk);
      #1;
      check("load_ready", 64'(bus.ld_ready), 64'd1);
      check("load_stall", 64'(bus.cpu_stall), 64'd1);
      check("load_fvalid", 64'(bus.fetch_valid), 64'd0);
      check("load_memen", 64'(bus.mem_en), 64'd0);
      bus.fetch_req = 1'b0;

      // Three writes with gaps, then release
      we_base = we_cnt;
      for (int i = 0; i < 3; i++) begin
         wr(AW'(i), words[i]);
         idle();
         check("gap_we", 64'(bus.mem_we), 64'd0);
      end
      check("load_wc3", 64'(bus.word_count), 64'd3);
      check("we_pulses", 64'(we_cnt - we_base), 64'd3);
      for (int i = 0; i < 3; i++) check("mem_word", 64'(mem_word(i)), 64'(words[i]));
      @(negedge clk);
      bus.load_mode = 1'b0;
      n = 0;
      stop = 1'b0;
      for (int k = 0; k < 12 && !stop; k++) begin
         @(negedge clk);
         #1;
         if (bus.cpu_rst_req) n++;
         else if (n > 0) stop = 1'b1;
      end
      check("rel_cycles", 64'(n), 64'd4);
      check("rel_run", 64'(bus.cpu_stall), 64'd0);

      // Reload; re-enter LOAD from RELEASE without clearing word_count
      @(negedge clk);
      bus.load_mode = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reload_wc0", 64'(bus.word_count), 64'd0);
      wr(AW'(8), 32'h1111_0008);
      idle();
      wr(AW'(9), 32'h1111_0009);
      idle();
      wr(AW'(10), 32'h1111_000A);
      idle();
      check("reload_wc3", 64'(bus.word_count), 64'd3);
      @(negedge clk);
      bus.load_mode = 1'b0;
      @(negedge clk);
      #1;
      check("rel1_req", 64'(bus.cpu_rst_req), 64'd1);
      @(negedge clk);
      bus.load_mode = 1'b1;
      #1;
      check("rel2_req", 64'(bus.cpu_rst_req), 64'd1);
      @(negedge clk);
      #1;
      check("back_ready", 64'(bus.ld_ready), 64'd1);
      check("back_rstreq", 64'(bus.cpu_rst_req), 64'd0);
      check("back_wc", 64'(bus.word_count), 64'd3);
      wr(AW'(11), 32'h1111_000B);
      idle();
      check("back_wc4", 64'(bus.word_count), 64'd4);

      // Reset mid-LOAD with a write presented
      @(negedge clk);
      rst = 1'b1;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = AW'(20);
      bus.ld_data  = 32'hDEAD_BEEF;
      #1;
      check("rstw_we", 64'(bus.mem_we), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.load_mode = 1'b0;
      #1;
      check("rstw_stall", 64'(bus.cpu_stall), 64'd0);
      check("rstw_ready", 64'(bus.ld_ready), 64'd0);
      check("rstw_wc", 64'(bus.word_count), 64'd0);
      check("rstw_mem", 64'(mem_word(20)), 64'(init_word(20)));

      // Reset discards an in-flight read
      @(negedge clk);
      rst = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0020;
      @(negedge clk);
      rst = 1'b0;
      bus.fetch_req = 1'b0;
      #1;
      check("rstr_fvalid", 64'(bus.fetch_valid), 64'd0);

      // Misaligned fetch reads a word written by the first load
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0000_0006;
      #1;
      check("mis_addr", 64'(bus.mem_addr), 64'd1);
      @(negedge clk);
      bus.fetch_req = 1'b0;
      #1;
      check("mis_fvalid", 64'(bus.fetch_valid), 64'd1);
      check("mis_flag", 64'(bus.fetch_misalign), 64'd1);
      check("mis_rdata", 64'(bus.fetch_rdata), 64'h0010_0093);

`ifdef IMEM_ARB_CHECKSUM_EN
      @(negedge clk);
      bus.load_mode = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("csum_clr", 64'(bus.ld_checksum), 64'd0);
      wr(AW'(30), 32'hFFFF_0000);
      wr(AW'(31), 32'h0F0F_0F0F);
      idle();
      check("csum_val", 64'(bus.ld_checksum), 64'hF0F0_0F0F);
      bus.load_mode = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check("csum_hold", 64'(bus.ld_checksum), 64'hF0F0_0F0F);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
